// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
    parameter int DATA_WIDTH   = 64,
    parameter int INST_WIDTH   = 32,
    parameter int IMM_TYPE_NUM = 8,
    parameter int TAG_WIDTH    = 64
);
    localparam int TYPE_W = $clog2(IMM_TYPE_NUM);

    logic                  in_valid;
    logic                  in_ready;
    logic [INST_WIDTH-1:0] in_inst;
    logic [TYPE_W-1:0]     in_imm_type;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_imm;
    logic [TYPE_W-1:0]     out_type;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  out_illegal;

    modport master (
        output in_valid, in_inst, in_imm_type, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_type, out_tag, out_illegal
    );

    modport slave (
        input  in_valid, in_inst, in_imm_type, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_type, out_tag, out_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - one-cycle immediate generator with valid/ready flow control
// Optional macro IMM_GEN_SKID_EN adds a skid register so in_ready is a pure flop output.
module imm_gen_pipe #(
    parameter int DATA_WIDTH   = 64,
    parameter int INST_WIDTH   = 32,
    parameter int IMM_TYPE_NUM = 8,
    parameter int TAG_WIDTH    = 64
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    localparam int TYPE_W  = $clog2(IMM_TYPE_NUM);
    localparam int SHAMT_W = $clog2(DATA_WIDTH);

    localparam logic [TYPE_W-1:0] T_I     = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] T_SHAMT = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] T_S     = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] T_B     = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] T_U     = TYPE_W'(4);
    localparam logic [TYPE_W-1:0] T_J     = TYPE_W'(5);
    localparam logic [TYPE_W-1:0] T_ZIMM  = TYPE_W'(6);
    localparam logic [TYPE_W-1:0] T_AUTO  = TYPE_W'(7);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [TYPE_W-1:0]     typ;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  illegal;
    } beat_t;

    logic [INST_WIDTH-1:0] inst;
    logic [6:0]            opcode;
    logic [2:0]            funct3;
    logic [TYPE_W-1:0]     res_type;
    logic                  narrow_shamt;
    logic                  illegal;
    logic [DATA_WIDTH-1:0] imm;
    beat_t                 in_beat;

    assign inst   = bus.in_inst;
    assign opcode = inst[6:0];
    assign funct3 = inst[14:12];

    always_comb begin
        res_type     = bus.in_imm_type;
        narrow_shamt = 1'b0;
        illegal      = 1'b0;
        if (bus.in_imm_type == T_AUTO) begin
            res_type = T_I;
            case (opcode)
                7'b0000011, 7'b1100111: res_type = T_I;
                7'b0010011: res_type = (funct3[1:0] == 2'b01) ? T_SHAMT : T_I;
                7'b0011011: begin
                    // word-sized shifts only exist on the 64-bit datapath
                    if (DATA_WIDTH == 64) begin
                        res_type     = (funct3[1:0] == 2'b01) ? T_SHAMT : T_I;
                        narrow_shamt = 1'b1;
                    end else begin
                        illegal = 1'b1;
                    end
                end
                7'b0100011: res_type = T_S;
                7'b1100011: res_type = T_B;
                7'b0110111, 7'b0010111: res_type = T_U;
                7'b1101111: res_type = T_J;
                7'b1110011: res_type = funct3[2] ? T_ZIMM : T_I;
                default:    illegal = 1'b1;
            endcase
        end

        case (res_type)
            T_I:     imm = DATA_WIDTH'($signed(inst[31:20]));
            T_SHAMT: imm = narrow_shamt ? DATA_WIDTH'(inst[24:20]) : DATA_WIDTH'(inst[SHAMT_W+19:20]);
            T_S:     imm = DATA_WIDTH'($signed({inst[31:25], inst[11:7]}));
            T_B:     imm = DATA_WIDTH'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
            T_U:     imm = DATA_WIDTH'($signed({inst[31:12], 12'b0}));
            T_J:     imm = DATA_WIDTH'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
            T_ZIMM:  imm = DATA_WIDTH'(inst[19:15]);
            default: imm = '0;
        endcase

        if (illegal) begin
            imm      = '0;
            res_type = T_I;
        end

        in_beat         = '0;
        in_beat.imm     = imm;
        in_beat.typ     = res_type;
        in_beat.tag     = bus.in_tag;
        in_beat.illegal = illegal;
    end

    logic  in_ready;
    logic  accept;
    logic  pop;
    beat_t out_q, out_d;
    logic  out_valid_q, out_valid_d;

    assign pop    = out_valid_q && bus.out_ready;
    assign accept = bus.in_valid && in_ready && !flush;

`ifdef IMM_GEN_SKID_EN
    beat_t skid_q, skid_d;
    logic  skid_valid_q, skid_valid_d;

    // skid_valid_q is a flop, so in_ready never depends on out_ready
    assign in_ready = rst_n && !skid_valid_q;

    always_comb begin
        out_d        = out_q;
        out_valid_d  = out_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (flush) begin
            out_d        = '0;
            out_valid_d  = 1'b0;
            skid_d       = '0;
            skid_valid_d = 1'b0;
        end else if (skid_valid_q) begin
            if (pop) begin
                out_d        = skid_q;
                skid_d       = '0;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!out_valid_q || pop) begin
                out_d       = in_beat;
                out_valid_d = 1'b1;
            end else begin
                skid_d       = in_beat;
                skid_valid_d = 1'b1;
            end
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q        <= '0;
            out_valid_q  <= 1'b0;
            skid_q       <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            out_q        <= out_d;
            out_valid_q  <= out_valid_d;
            skid_q       <= skid_d;
            skid_valid_q <= skid_valid_d;
        end
    end
`else
    assign in_ready = rst_n && (!out_valid_q || bus.out_ready);

    always_comb begin
        out_d       = out_q;
        out_valid_d = out_valid_q;
        if (flush) begin
            out_d       = '0;
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_d       = in_beat;
            out_valid_d = 1'b1;
        end else if (pop) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end
`endif

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid_q;
    assign bus.out_imm     = out_q.imm;
    assign bus.out_type    = out_q.typ;
    assign bus.out_tag     = out_q.tag;
    assign bus.out_illegal = out_q.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe with arithmetic reference model
module tb_imm_gen_pipe;
    localparam int DW = 64;
    localparam int TW = 64;

`ifdef IMM_GEN_SKID_EN
    localparam int STALL_ACCEPTS = 2;
`else
    localparam int STALL_ACCEPTS = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.DATA_WIDTH(DW), .INST_WIDTH(32), .IMM_TYPE_NUM(8), .TAG_WIDTH(TW)) bus ();

    imm_gen_pipe #(.DATA_WIDTH(DW), .INST_WIDTH(32), .IMM_TYPE_NUM(8), .TAG_WIDTH(TW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct packed {
        logic [63:0] imm;
        logic [2:0]  typ;
        logic [63:0] tag;
        logic        ill;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] bp_tags[$];
    bit          bp_rec = 0;
    int          ntests = 0;
    int          nfail = 0;
    logic [6:0]  ops[10];

    function automatic longint sx(longint v, int bits);
        if (v >= (longint'(1) << (bits - 1))) return v - (longint'(1) << bits);
        return v;
    endfunction

    function automatic exp_t model(logic [31:0] i, logic [2:0] t, logic [63:0] tag);
        exp_t   e;
        longint u, v;
        int     op, f3, ty;
        bit     ill, narrow;
        u = longint'(i);
        op = int'(i[6:0]);
        f3 = int'(i[14:12]);
        ty = int'(t);
        ill = 0;
        narrow = 0;
        if (t == 3'd7) begin
            if (op == 'h03 || op == 'h67) ty = 0;
            else if (op == 'h13) ty = (f3 == 1 || f3 == 5) ? 1 : 0;
            else if (op == 'h1B) begin ty = (f3 == 1 || f3 == 5) ? 1 : 0; narrow = 1; end
            else if (op == 'h23) ty = 2;
            else if (op == 'h63) ty = 3;
            else if (op == 'h37 || op == 'h17) ty = 4;
            else if (op == 'h6F) ty = 5;
            else if (op == 'h73) ty = (f3 >= 4) ? 6 : 0;
            else ill = 1;
        end
        case (ty)
            0: v = sx((u >> 20) & 'hFFF, 12);
            1: v = (u >> 20) & (narrow ? 31 : 63);
            2: v = sx(((u >> 25) << 5) | ((u >> 7) & 31), 12);
            3: v = sx((((u >> 31) & 1) << 12) | (((u >> 7) & 1) << 11) |
                      (((u >> 25) & 63) << 5) | (((u >> 8) & 15) << 1), 13);
            4: v = sx(u & 'hFFFFF000, 32);
            5: v = sx((((u >> 31) & 1) << 20) | (((u >> 12) & 255) << 12) |
                      (((u >> 20) & 1) << 11) | (((u >> 21) & 1023) << 1), 21);
            default: v = (u >> 15) & 31;
        endcase
        if (ill) begin v = 0; ty = 0; end
        e.imm = 64'(v);
        e.typ = 3'(ty);
        e.tag = tag;
        e.ill = ill;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_beat(input string nm, input exp_t a, input exp_t e);
        ntests++;
        if (a !== e) begin
            nfail++;
            $display("FAIL %s: got imm=%h type=%0d tag=%h ill=%b expected imm=%h type=%0d tag=%h ill=%b",
                     nm, a.imm, a.typ, a.tag, a.ill, e.imm, e.typ, e.tag, e.ill);
        end
    endtask

    task automatic rand_beat(input logic [63:0] tag);
        logic [31:0] inst;
        inst = $urandom;
        if ($urandom_range(0, 3) != 0) inst[6:0] = ops[$urandom_range(0, 9)];
        bus.in_inst     = inst;
        bus.in_imm_type = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'($urandom_range(0, 6));
        bus.in_tag      = tag;
    endtask

    // Monitor: pop/compare presented beats, check stall stability, push accepted beats.
    exp_t held;
    bit   stall_prev = 0;
    always @(negedge clk) begin
        exp_t a, e;
        a = '{bus.out_imm, bus.out_type, bus.out_tag, bus.out_illegal};
        if (stall_prev && rst_n) chk_beat("hold_stable", a, held);
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                ntests++;
                nfail++;
                $display("FAIL sb_unexpected: got beat tag=%h expected no beat", bus.out_tag);
            end else begin
                e = sb.pop_front();
                chk_beat("scoreboard", a, e);
            end
            if (bp_rec) bp_tags.push_back(bus.out_tag);
        end
        stall_prev = rst_n && !flush && bus.out_valid && !bus.out_ready;
        held = a;
        if (!rst_n || flush) sb.delete();
        else if (bus.in_valid && bus.in_ready)
            sb.push_back(model(bus.in_inst, bus.in_imm_type, bus.in_tag));
    end

    task automatic direct(input logic [31:0] inst, input logic [63:0] eimm, input logic [2:0] etyp,
                          input logic eill, input string nm);
        @(posedge clk); #1;
        bus.out_ready   = 1'b1;
        bus.in_valid    = 1'b1;
        bus.in_inst     = inst;
        bus.in_imm_type = 3'd7;
        bus.in_tag      = 64'($urandom);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_valid"}, 64'(bus.out_valid), 64'd1);
        chk({nm, "_imm"}, bus.out_imm, eimm);
        chk({nm, "_type"}, 64'(bus.out_type), 64'(etyp));
        chk({nm, "_illegal"}, 64'(bus.out_illegal), 64'(eill));
    endtask

    task automatic fill_stall();
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        rand_beat(64'($urandom));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (!bus.in_ready) break;
            @(posedge clk); #1;
            rand_beat(64'($urandom));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_out_valid"}, 64'(bus.out_valid), 64'd0);
        chk({nm, "_out_imm"}, bus.out_imm, 64'd0);
        chk({nm, "_out_type"}, 64'(bus.out_type), 64'd0);
        chk({nm, "_out_tag"}, bus.out_tag, 64'd0);
        chk({nm, "_out_illegal"}, 64'(bus.out_illegal), 64'd0);
        chk({nm, "_in_ready"}, 64'(bus.in_ready), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, idx, waited;
        bit took;
        ops[0] = 7'h03; ops[1] = 7'h67; ops[2] = 7'h13; ops[3] = 7'h1B; ops[4] = 7'h23;
        ops[5] = 7'h63; ops[6] = 7'h37; ops[7] = 7'h17; ops[8] = 7'h6F; ops[9] = 7'h73;
        bus.in_valid = 1'b0;
        bus.in_inst = '0;
        bus.in_imm_type = '0;
        bus.in_tag = '0;
        bus.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("release_in_ready", 64'(bus.in_ready), 64'd1);

        direct(32'hFFF00093, 64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 1'b0, "addi");
        direct(32'h800000B7, 64'hFFFF_FFFF_8000_0000, 3'd4, 1'b0, "lui");
        direct(32'h80000063, 64'hFFFF_FFFF_FFFF_F000, 3'd3, 1'b0, "beq");
        direct(32'h0020006F, 64'd2, 3'd5, 1'b0, "jal");
        direct(32'h03F09093, 64'd63, 3'd1, 1'b0, "slli63");
        direct(32'h0000007F, 64'd0, 3'd0, 1'b1, "illegal");
        repeat (2) @(posedge clk);

        // back-pressure: tags 1..4 offered back-to-back, downstream stalled for 3 cycles
        @(posedge clk); #1;
        bp_rec = 1;
        bp_tags.delete();
        bus.out_ready = 1'b0;
        idx = 0;
        acc = 0;
        bus.in_valid = 1'b1;
        rand_beat(64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk); #1;
            if (took) begin
                acc++;
                idx++;
                rand_beat(64'(idx + 1));
            end
        end
        chk("bp_accepts_under_stall", 64'(acc), 64'(STALL_ACCEPTS));
        @(negedge clk);
        chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
        waited = 0;
        while (idx < 4 && waited < 20) begin
            @(negedge clk);
            took = bus.in_ready;
            @(posedge clk); #1;
            waited++;
            if (took) begin
                idx++;
                rand_beat(64'(idx + 1));
            end
        end
        bus.in_valid = 1'b0;
        chk("bp_all_accepted", 64'(idx), 64'd4);
        repeat (4) @(posedge clk);
        #1;
        bp_rec = 0;
        chk("bp_tag_count", 64'(bp_tags.size()), 64'd4);
        for (int k = 0; k < 4 && k < bp_tags.size(); k++)
            chk("bp_tag_order", bp_tags[k], 64'(k + 1));

        // flush with full buffers and a beat offered
        fill_stall();
        @(posedge clk); #1;
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_tag = 64'hDEAD;
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_out_valid", 64'(bus.out_valid), 64'd0);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("flush_no_beat", 64'(bus.out_valid), 64'd0);
        end

        // flush beats an accept even with room in the buffer
        @(posedge clk); #1;
        flush = 1'b1;
        bus.in_valid = 1'b1;
        rand_beat(64'hBEEF);
        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("flush_wins_accept", 64'(bus.out_valid), 64'd0);

        // reset during a stall with full buffers
        fill_stall();
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("reset_in_ready_low", 64'(bus.in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("stall_reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("stall_release_in_ready", 64'(bus.in_ready), 64'd1);

        // randomized traffic with flushes and back-pressure
        took = 0;
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            if (!bus.in_valid || took) begin
                if ($urandom_range(0, 3) != 0) begin
                    bus.in_valid = 1'b1;
                    rand_beat({32'($urandom), 32'(c)});
                end else begin
                    bus.in_valid = 1'b0;
                end
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            flush = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            took = bus.in_valid && bus.in_ready && !flush;
        end

        @(posedge clk); #1;
        flush = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        waited = 0;
        while (sb.size() != 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        @(negedge clk);
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_out_valid", 64'(bus.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
